// File: rtl/spis_bus_pkg.sv
// rtl/spis_bus_pkg.sv - shared bus addresses, status bit layout and TX state encoding
package spis_bus_pkg;

   localparam logic [11:0] TX_ADDR     = 12'hFFF;
   localparam logic [11:0] STATUS_ADDR = 12'hFFE;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_BUSY  = 3;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte-wide FIFO with occupancy count; a pop frees a slot for a same-edge push
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - memory-mapped 8N1 transmitter: bus decode, write edge detect, overflow flag, TX FSM
module bus_uart_tx
   import spis_bus_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] addressBus,
   inout  wire  [7:0]  dataBus,
   input  logic        write,
   output logic        txd,
   output logic        txBusy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t              state;
   tx_state_t              state_n;
   logic [CW-1:0]          baud_cnt;
   logic [CW-1:0]          baud_n;
   logic [2:0]             bit_cnt;
   logic [2:0]             bit_n;
   logic [7:0]             shifter;
   logic [7:0]             shift_n;
   logic                   pop;
   logic                   baud_end;

   logic                   write_q;
   logic                   wr_accept;
   logic                   status_rd;
   logic                   overflow;
   logic [7:0]             status;

   logic [7:0]             fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (wr_accept),
      .pop   (pop),
      .wdata (dataBus),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Only the rising edge of the strobe pushes, so a held strobe queues one byte
   assign wr_accept = write && !write_q && (addressBus == TX_ADDR);
   assign status_rd = !write && (addressBus == STATUS_ADDR);
   assign txBusy    = (state != IDLE) || (fifo_count != '0);
   assign baud_end  = (baud_cnt == BAUD_LAST);

   always_comb begin
      status           = '0;
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_OVF]   = overflow;
      status[ST_BUSY]  = txBusy;
   end

   assign dataBus = status_rd ? status : 8'hzz;

   always_ff @(posedge clock) begin
      if (reset) begin
         write_q  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         write_q <= write;
         if (wr_accept && fifo_full && !pop) begin
            overflow <= 1'b1;
         end else if (status_rd) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shifter  <= '0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shifter  <= shift_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_cnt;
      shift_n = shifter;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = fifo_rdata;
               baud_n  = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + CW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_n  = '0;
               shift_n = {1'b0, shifter[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_n = bit_cnt + 3'd1;
               end
            end else begin
               baud_n = baud_cnt + CW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_n = '0;
               // Chain straight into the next start bit when more bytes wait
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = fifo_rdata;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud_cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      case (state)
         START:   txd = 1'b0;
         DATA:    txd = shifter[0];
         default: txd = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb/tb_bus_uart_tx.sv - directed bench for bus_uart_tx with CLKS_PER_BIT=4, DEPTH=4
module tb_bus_uart_tx;

   localparam int CPB = 4;
   localparam logic [11:0] IDLE_ADDR = 12'h000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        write = 1'b0;
   logic [11:0] address = IDLE_ADDR;
   logic [7:0]  drv_data = 8'h00;
   logic        drv_en = 1'b0;
   wire  [7:0]  data_bus;
   logic        txd;
   logic        tx_busy;

   int checks = 0;
   int failures = 0;

   assign data_bus = drv_en ? drv_data : 8'hzz;

   bus_uart_tx #(.DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
      .clock      (clock),
      .reset      (reset),
      .addressBus (address),
      .dataBus    (data_bus),
      .write      (write),
      .txd        (txd),
      .txBusy     (tx_busy)
   );

   always #5 clock = ~clock;

   // Line receiver: decodes frames from txd, sampling each bit one cycle into its slot
   typedef struct {
      logic [7:0] data;
      logic       ok;
      int         start;
   } frame_t;

   frame_t     frames[$];
   int         cyc = 0;
   logic       rx_active = 1'b0;
   int         rx_pos = 0;
   int         rx_start = 0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ok = 1'b0;

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (reset) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (txd === 1'b0) begin
            rx_active = 1'b1;
            rx_pos    = 0;
            rx_start  = cyc;
            rx_ok     = 1'b1;
            rx_data   = 8'h00;
         end
      end else begin
         rx_pos = rx_pos + 1;
         if (rx_pos == 2 && txd !== 1'b0) rx_ok = 1'b0;
         if (rx_pos >= CPB + 1 && rx_pos <= 8 * CPB + 1 && ((rx_pos - 1) % CPB) == 0)
            rx_data[(rx_pos - 1) / CPB - 1] = txd;
         if (rx_pos == 9 * CPB + 1) begin
            if (txd !== 1'b1) rx_ok = 1'b0;
            frames.push_back('{data: rx_data, ok: rx_ok, start: rx_start});
            rx_active = 1'b0;
         end
      end
   end

   task automatic write_byte(input logic [11:0] addr, input logic [7:0] value);
      @(negedge clock);
      address  = addr;
      drv_data = value;
      drv_en   = 1'b1;
      write    = 1'b1;
      @(negedge clock);
      write   = 1'b0;
      drv_en  = 1'b0;
      address = IDLE_ADDR;
   endtask

   task automatic read_status(output logic [7:0] value);
      @(negedge clock);
      address = 12'hFFE;
      write   = 1'b0;
      drv_en  = 1'b0;
      #1 value = data_bus;
      @(negedge clock);
      address = IDLE_ADDR;
   endtask

   task automatic wait_frames(input int n, input int budget);
      for (int k = 0; k < budget && frames.size() < n; k++) @(negedge clock);
      repeat (60) @(negedge clock);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      int lows = 0;
      repeat (3) @(negedge clock);
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
      reset = 1'b0;
      read_status(v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL reset_status: got %h expected 01", v); end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
      repeat (100) begin
         @(negedge clock);
         if (txd !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin failures++; $display("FAIL reset_idle_line: %0d low cycles, expected 0", lows); end
   endtask

   task automatic test_single_frame();
      logic [7:0] pat = 8'hA5;
      logic       exp;
      int         slot;
      frames.delete();
      write_byte(12'hFFF, pat);
      checks++;
      if (tx_busy !== 1'b1) begin failures++; $display("FAIL busy_after_push: got %b expected 1", tx_busy); end
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL txd_push_cycle: got %b expected 1", txd); end
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge clock);
         slot = i / CPB;
         exp  = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : pat[slot - 1];
         checks++;
         if (txd !== exp) begin failures++; $display("FAIL frame_a5_bit cycle %0d: got %b expected %b", i, txd, exp); end
         checks++;
         if (tx_busy !== 1'b1) begin failures++; $display("FAIL frame_a5_busy cycle %0d: got %b expected 1", i, tx_busy); end
      end
      @(negedge clock);
      checks++;
      if (txd !== 1'b1 || tx_busy !== 1'b0) begin
         failures++; $display("FAIL frame_a5_end: txd %b busy %b expected 1 0", txd, tx_busy);
      end
      checks++;
      if (frames.size() != 1) begin failures++; $display("FAIL frame_a5_count: got %0d expected 1", frames.size()); end
      else if (frames[0].data !== pat || frames[0].ok !== 1'b1) begin
         failures++; $display("FAIL frame_a5_rx: got %h ok %b expected a5 ok 1", frames[0].data, frames[0].ok);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [7:0] v;
      frames.delete();
      for (int i = 0; i < 6; i++) write_byte(12'hFFF, bytes[i]);
      read_status(v);
      checks++;
      if (v !== 8'h0E) begin failures++; $display("FAIL b2b_status_ovf: got %h expected 0e", v); end
      read_status(v);
      checks++;
      if (v !== 8'h0A) begin failures++; $display("FAIL b2b_status_cleared: got %h expected 0a", v); end
      wait_frames(5, 400);
      checks++;
      if (frames.size() != 5) begin failures++; $display("FAIL b2b_count: got %0d expected 5", frames.size()); end
      for (int i = 0; i < 5 && i < frames.size(); i++) begin
         checks++;
         if (frames[i].data !== bytes[i] || frames[i].ok !== 1'b1) begin
            failures++; $display("FAIL b2b_data %0d: got %h ok %b expected %h ok 1", i, frames[i].data, frames[i].ok, bytes[i]);
         end
         if (i > 0) begin
            checks++;
            if (frames[i].start - frames[i-1].start != 10 * CPB) begin
               failures++; $display("FAIL b2b_gap %0d: spacing %0d expected %0d", i, frames[i].start - frames[i-1].start, 10 * CPB);
            end
         end
      end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end: got %b expected 0", tx_busy); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] v;
      frames.delete();
      for (int i = 0; i < 5; i++) write_byte(12'hFFF, 8'h80 + 8'(i));
      // next push lands on the edge where the stop bit ends and the FIFO pops
      repeat (10 * CPB - 9) @(negedge clock);
      write_byte(12'hFFF, 8'h85);
      read_status(v);
      checks++;
      if (v !== 8'h0A) begin failures++; $display("FAIL pushpop_status: got %h expected 0a", v); end
      wait_frames(6, 500);
      checks++;
      if (frames.size() != 6) begin failures++; $display("FAIL pushpop_count: got %0d expected 6", frames.size()); end
      for (int i = 0; i < 6 && i < frames.size(); i++) begin
         checks++;
         if (frames[i].data !== 8'h80 + 8'(i)) begin
            failures++; $display("FAIL pushpop_data %0d: got %h expected %h", i, frames[i].data, 8'h80 + 8'(i));
         end
      end
   endtask

   task automatic test_held_write();
      int peak = 0;
      frames.delete();
      @(negedge clock);
      address  = 12'hFFF;
      drv_data = 8'h3C;
      drv_en   = 1'b1;
      write    = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (int'(dut.fifo_count) > peak) peak = int'(dut.fifo_count);
      end
      write   = 1'b0;
      drv_en  = 1'b0;
      address = IDLE_ADDR;
      repeat (10 * CPB + 20) begin
         @(negedge clock);
         if (int'(dut.fifo_count) > peak) peak = int'(dut.fifo_count);
      end
      checks++;
      if (peak != 1) begin failures++; $display("FAIL held_peak: got %0d expected 1", peak); end
      checks++;
      if (frames.size() != 1) begin failures++; $display("FAIL held_count: got %0d expected 1", frames.size()); end
      else if (frames[0].data !== 8'h3C) begin
         failures++; $display("FAIL held_data: got %h expected 3c", frames[0].data);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] v;
      int lows = 0;
      frames.delete();
      for (int i = 0; i < 3; i++) write_byte(12'hFFF, 8'hC0 + 8'(i));
      repeat (16) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL midreset_txd: got %b expected 1", txd); end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", tx_busy); end
      @(negedge clock);
      reset = 1'b0;
      frames.delete();
      read_status(v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL midreset_status: got %h expected 01", v); end
      repeat (100) begin
         @(negedge clock);
         if (txd !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0 || frames.size() != 0) begin
         failures++; $display("FAIL midreset_quiet: %0d low cycles %0d frames, expected 0 0", lows, frames.size());
      end
   endtask

   task automatic test_ignored_access();
      logic [7:0] v;
      int lows = 0;
      frames.delete();
      @(negedge clock);
      address  = 12'h123;
      write    = 1'b0;
      drv_data = 8'h00;
      drv_en   = 1'b1;
      #1 v = data_bus;
      checks++;
      if (v !== 8'h00) begin failures++; $display("FAIL other_addr_bus: got %h expected 00", v); end
      @(negedge clock);
      address  = 12'hFFE;
      drv_data = 8'h55;
      write    = 1'b1;
      #1 v = data_bus;
      checks++;
      if (v !== 8'h55) begin failures++; $display("FAIL status_write_bus: got %h expected 55", v); end
      @(negedge clock);
      write   = 1'b0;
      drv_en  = 1'b0;
      address = IDLE_ADDR;
      write_byte(12'h123, 8'h55);
      read_status(v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL ignored_status: got %h expected 01", v); end
      repeat (100) begin
         @(negedge clock);
         if (txd !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0 || frames.size() != 0) begin
         failures++; $display("FAIL ignored_quiet: %0d low cycles %0d frames, expected 0 0", lows, frames.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_push_pop_full();
      test_held_write();
      test_reset_mid_frame();
      test_ignored_access();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule
